// File: rtl/ifetch_pkg.sv
// Shared types and default sizing for the instruction-fetch front end.
package ifetch_pkg;

  parameter int ADDR_W  = 64;
  parameter int INST_W  = 32;
  parameter int DEPTH   = 4;
  parameter int PC_STEP = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO with clear; output word is read straight from registered storage.
module ifetch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Storage, pointers and occupancy; clear drops contents but leaves storage untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: credit-limited in-order requests, PC side-queue and
// instruction FIFO towards the decoder, with flush draining of in-flight responses.
module ifetch_unit #(
  parameter int ADDR_W = ifetch_pkg::ADDR_W,
  parameter int INST_W = ifetch_pkg::INST_W,
  parameter int DEPTH  = ifetch_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pc_adv_o,
  input  logic              flush_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_rsp_valid_i,
  input  logic [INST_W-1:0] mem_rsp_data_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              err_o
);

  import ifetch_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INST_W + ADDR_W;

  state_e            state_r;
  state_e            state_next_s;
  logic [CW-1:0]     outstanding_r;
  logic [CW-1:0]     outstanding_next_s;
  logic [CW-1:0]     inst_count_s;
  logic [CW:0]       credit_sum_s;
  logic              credit_s;
  logic              req_hs_s;
  logic              rsp_known_s;
  logic              rsp_accept_s;
  logic              inst_pop_s;
  logic              inst_empty_s;
  logic              inst_full_s;
  logic              err_r;
  logic [EW-1:0]     inst_dout_s;
  logic [ADDR_W-1:0] pc_head_s;
  logic [CW-1:0]     pc_count_s;
  logic              pc_full_s;
  logic              pc_empty_s;
  logic              unused_s;

  // Credit covers both buffered and still-in-flight instructions, so the FIFO cannot overflow.
  assign credit_sum_s = {1'b0, inst_count_s} + {1'b0, outstanding_r};
  assign credit_s     = (credit_sum_s < (CW+1)'(DEPTH));

  assign mem_req_addr_o = pc_i;
  assign req_hs_s       = mem_req_valid_o & mem_req_ready_i;
  assign pc_adv_o       = req_hs_s;
  // A response with nothing outstanding is a protocol error and is otherwise ignored.
  assign rsp_known_s    = mem_rsp_valid_i & (outstanding_r != '0);
  assign rsp_accept_s   = rsp_known_s & ~flush_i & (state_r != DRAIN);
  assign inst_valid_o   = ~inst_empty_s;
  assign inst_pop_s     = inst_valid_o & inst_ready_i;
  assign inst_o         = inst_dout_s[INST_W-1:0];
  assign inst_pc_o      = inst_dout_s[EW-1:INST_W];
  assign err_o          = err_r;
  assign unused_s       = ^{inst_full_s, pc_count_s, pc_full_s, pc_empty_s};

  assign outstanding_next_s = outstanding_r + CW'(req_hs_s) - CW'(rsp_known_s);

  // State, outstanding counter and sticky error register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= FETCH;
      outstanding_r <= '0;
      err_r         <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      outstanding_r <= outstanding_next_s;
      err_r         <= err_r | (mem_rsp_valid_i & (outstanding_r == '0));
    end
  end

  // Next-state selection; flush overrides the normal fetch/stall flow.
  always_comb begin
    state_next_s = state_r;
    if (flush_i) begin
      if (outstanding_next_s != '0) begin
        state_next_s = DRAIN;
      end else begin
        state_next_s = FETCH;
      end
    end else begin
      case (state_r)
        FETCH: begin
          if (!credit_s && !inst_pop_s) begin
            state_next_s = STALL;
          end else begin
            state_next_s = FETCH;
          end
        end
        STALL: begin
          if (credit_s) begin
            state_next_s = FETCH;
          end else begin
            state_next_s = STALL;
          end
        end
        DRAIN: begin
          if (outstanding_next_s == '0) begin
            state_next_s = FETCH;
          end else begin
            state_next_s = DRAIN;
          end
        end
        default: state_next_s = FETCH;
      endcase
    end
  end

  // Request valid per state; held low while reset is asserted.
  always_comb begin
    mem_req_valid_o = 1'b0;
    case (state_r)
      FETCH:   mem_req_valid_o = rst & credit_s;
      STALL:   mem_req_valid_o = 1'b0;
      DRAIN:   mem_req_valid_o = 1'b0;
      default: mem_req_valid_o = 1'b0;
    endcase
  end

  ifetch_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_pc_q (
    .clk   (clk),
    .rst   (rst),
    .push  (req_hs_s),
    .pop   (rsp_accept_s),
    .clear (flush_i),
    .din   (pc_i),
    .dout  (pc_head_s),
    .count (pc_count_s),
    .full  (pc_full_s),
    .empty (pc_empty_s)
  );

  ifetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_inst_q (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_accept_s),
    .pop   (inst_pop_s),
    .clear (flush_i),
    .din   ({pc_head_s, mem_rsp_data_i}),
    .dout  (inst_dout_s),
    .count (inst_count_s),
    .full  (inst_full_s),
    .empty (inst_empty_s)
  );

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch front end on the consuming side of the program counter. It takes the current PC, issues in-order read requests to instruction memory, and buffers returned instructions in a small FIFO. It presents each instruction with its PC to the decoder over a valid/ready handshake. It also tells the PC when a fetch has been accepted so the PC can advance by 4, and discards in-flight fetches on a flush.

## Interface
Parameters:
- ADDR_W, 64, PC / memory address width
- INST_W, 32, instruction width
- DEPTH, 4, FIFO entries; power of two, ≥2

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-low
- pc_i  input  ADDR_W  current PC from the program counter
- pc_adv_o  output  1  one-cycle pulse when a fetch request handshakes; PC advances by 4
- flush_i  input  1  discard FIFO contents and all in-flight responses
- mem_req_valid_o  output  1  fetch request valid
- mem_req_ready_i  input  1  memory accepts request
- mem_req_addr_o  output  ADDR_W  fetch address, equal to pc_i
- mem_rsp_valid_i  input  1  response valid; in order; no backpressure
- mem_rsp_data_i  input  INST_W  fetched instruction
- inst_valid_o  output  1  FIFO head valid
- inst_ready_i  input  1  decoder accepts head
- inst_o  output  INST_W  head instruction
- inst_pc_o  output  ADDR_W  PC of head instruction
- err_o  output  1  sticky: response received with no fetch outstanding

## Operation
- **Credit rule.** A request is issued only when `count + outstanding < DEPTH`, so the FIFO can never overflow.
  - `count` is the FIFO occupancy, 0..DEPTH.
  - `outstanding` is the number of unanswered requests, 0..DEPTH.
  - Both counters are clog2(DEPTH)+1 bits wide.
- **PC tracking.** The request PC is pushed into a PC side-queue at request handshake. That PC is paired with the response data at response time and written to the FIFO.
- **FSM states and transitions:**
  - FETCH: drive mem_req_valid_o = 1 while credit is available. Go to STALL when credit is exhausted and no pop is occurring.
  - STALL: drive mem_req_valid_o = 0. Return to FETCH when credit becomes available.
  - DRAIN: entered on flush_i when outstanding after this cycle is > 0. Drive mem_req_valid_o = 0. Responses are dropped and decrement outstanding; no FIFO write. Go to FETCH when the last dropped response arrives.
- **Flush:**
  - Clears the FIFO, the PC side-queue and inst_valid_o at the next edge.
  - A request handshaking in the same cycle as flush counts as outstanding and its response is dropped.
  - A response arriving in the same cycle as flush is dropped.
  - Flush with nothing outstanding goes straight to FETCH.
- **Protocol error.** A response with outstanding == 0 is ignored and sets err_o; err_o clears only on reset.
- **Simultaneous push and pop** in the same cycle: count is unchanged.
- **Reset mid-operation:** counters, FIFO and state return to reset values. Responses still in flight are then protocol errors, which is accepted behaviour.

## Timing
- Reset values:
  - mem_req_valid_o = 0, pc_adv_o = 0, inst_valid_o = 0, err_o = 0.
  - inst_o = 0, inst_pc_o = 0.
  - State FETCH. In the first cycle after reset release, mem_req_valid_o = 1.
- Combinational signals:
  - mem_req_valid_o and mem_req_addr_o are combinational from state, the counters and pc_i.
  - pc_adv_o = mem_req_valid_o & mem_req_ready_i, in the same cycle as the handshake.
- Latency: a response captured at edge N gives inst_valid_o = 1 in cycle N+1. inst_o and inst_pc_o come from registered FIFO storage.
- Once inst_valid_o is asserted, it and inst_o/inst_pc_o stay stable until inst_ready_i or flush_i.
- Throughput: one fetch per cycle when memory responds at fixed latency L and L < DEPTH.

## Structure
- Package ifetch_pkg holds:
  - the state enum (FETCH, STALL, DRAIN);
  - default parameters ADDR_W, INST_W, DEPTH;
  - PC_STEP = 4.
- Sub-module ifetch_fifo: synchronous FIFO, parameterised width and depth.
  - Instantiated once with width INST_W+ADDR_W for instructions.
  - Instantiated once with width ADDR_W as the PC side-queue.
  - Provides push, pop, clear, count, and full/empty outputs.
- The top level holds the FSM, the outstanding counter, the credit logic and err_o.

## Test plan
1. Reset, then pc_i = 0x1000 increasing by 4 per pc_adv_o, memory ready always, latency 1 -> inst_o stream 0x1000.., one instruction per cycle, inst_pc_o 0x1000, 0x1004, …
2. DEPTH = 4, inst_ready_i = 0 -> exactly 4 requests issued, then mem_req_valid_o = 0 (STALL); one pop -> exactly one new request.
3. Latency 3 with 3 outstanding, flush_i pulsed -> state DRAIN, 3 responses dropped, FIFO empty, then requests resume at the new pc_i.
4. Flush in the same cycle as a request handshake and a response -> response dropped, new request counted and later dropped, inst_valid_o = 0 the cycle after.
5. mem_rsp_valid_i with outstanding = 0 -> err_o = 1 and stays high; FIFO unchanged.
6. Reset asserted mid-stream with FIFO at count 2 -> next cycle all outputs at reset values, count and outstanding = 0.
